// File: rtl/cordic_exp_collector.sv
// Collects results leaving a fixed-latency hyperbolic CORDIC, derives exp(+t)/exp(-t),
// and buffers them in a credit-protected first-word-fall-through FIFO.
module cordic_exp_collector #(
  parameter int PIPE_DEPTH = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int W          = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] cordic_x,
  input  logic [W-1:0] cordic_y,
  input  logic [W-1:0] cordic_theta,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_cosh,
  output logic [W-1:0] out_sinh,
  output logic [W:0]   out_exp_pos,
  output logic [W-1:0] out_exp_neg,
  output logic [W-1:0] out_residual,
  output logic         neg_sat,
  output logic         overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(PIPE_DEPTH + 1);
  localparam int CW = ((IW > OW) ? IW : OW) + 1;

  typedef struct packed {
    logic [W-1:0] cosh;
    logic [W-1:0] sinh;
    logic [W:0]   exp_pos;
    logic [W-1:0] exp_neg;
    logic [W-1:0] residual;
    logic         sat;
  } entry_t;

  logic [PIPE_DEPTH-1:0] vld;
  logic [IW-1:0]         inflight, inflight_next;
  logic [OW-1:0]         occupancy, occ_next;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  entry_t                mem [FIFO_DEPTH];
  entry_t                new_entry, head;
  logic [CW-1:0]         credit_sum;

  logic accept, capture, pop, full, write, drop, dec;

  assign accept    = in_valid & in_ready;
  assign capture   = vld[PIPE_DEPTH-1];
  assign out_valid = (occupancy != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (occupancy == OW'(FIFO_DEPTH));
  assign write     = capture & (~full | pop);
  assign drop      = capture & full & ~pop;
  // A capture not backed by a tracked accept (e.g. a corrupted valid bit) must not underflow credits.
  assign dec       = capture & (inflight != '0);

  // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    new_entry          = '0;
    new_entry.cosh     = cordic_x;
    new_entry.sinh     = cordic_y;
    new_entry.residual = cordic_theta;
    new_entry.sat      = (cordic_y > cordic_x);
    new_entry.exp_pos  = {1'b0, cordic_x} + {1'b0, cordic_y};
    new_entry.exp_neg  = new_entry.sat ? '0 : (cordic_x - cordic_y);
  end

  always_comb begin
    inflight_next = inflight;
    if (accept && !dec)      inflight_next = inflight + IW'(1);
    else if (!accept && dec) inflight_next = inflight - IW'(1);

    occ_next = occupancy;
    if (write && !pop)      occ_next = occupancy + OW'(1);
    else if (!write && pop) occ_next = occupancy - OW'(1);

    credit_sum = CW'(inflight_next) + CW'(occ_next);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld       <= '0;
      inflight  <= '0;
      occupancy <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      vld       <= {vld[PIPE_DEPTH-2:0], accept};
      inflight  <= inflight_next;
      occupancy <= occ_next;
      in_ready  <= (credit_sum < CW'(FIFO_DEPTH));
      if (write) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (drop)  overflow <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; outputs are masked by out_valid instead.
  always_ff @(posedge clk) begin
    if (write) mem[wr_ptr] <= new_entry;
  end

  assign head         = mem[rd_ptr];
  assign out_cosh     = out_valid ? head.cosh     : '0;
  assign out_sinh     = out_valid ? head.sinh     : '0;
  assign out_exp_pos  = out_valid ? head.exp_pos  : '0;
  assign out_exp_neg  = out_valid ? head.exp_neg  : '0;
  assign out_residual = out_valid ? head.residual : '0;
  assign neg_sat      = out_valid ? head.sat      : 1'b0;

endmodule

// File: tb/tb_cordic_exp_collector.sv
// Scoreboard bench for cordic_exp_collector with a 12-stage delay-line stand-in for the CORDIC.
module tb_cordic_exp_collector;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, out_valid, out_ready, neg_sat, overflow;
  logic [W-1:0] cordic_x, cordic_y, cordic_theta;
  logic [W-1:0] out_cosh, out_sinh, out_exp_neg, out_residual;
  logic [W:0]   out_exp_pos;
  logic [W-1:0] src_x, src_y, src_t;

  typedef struct packed {
    logic [W-1:0] cosh;
    logic [W-1:0] sinh;
    logic [W:0]   exp_pos;
    logic [W-1:0] exp_neg;
    logic [W-1:0] residual;
    logic         sat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   accepts = 0;
  int   pops = 0;

  always #5 clk = ~clk;

  // CORDIC stand-in: whatever is presented at an edge emerges 12 edges later.
  logic [3*W-1:0] pipe [12];
  always @(posedge clk) begin
    pipe[0] <= {src_x, src_y, src_t};
    for (int k = 1; k < 12; k++) pipe[k] <= pipe[k-1];
  end
  assign {cordic_x, cordic_y, cordic_theta} = pipe[11];

  cordic_exp_collector dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .cordic_x     (cordic_x),
    .cordic_y     (cordic_y),
    .cordic_theta (cordic_theta),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_cosh     (out_cosh),
    .out_sinh     (out_sinh),
    .out_exp_pos  (out_exp_pos),
    .out_exp_neg  (out_exp_neg),
    .out_residual (out_residual),
    .neg_sat      (neg_sat),
    .overflow     (overflow)
  );

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] t);
    exp_t e;
    e.cosh     = x;
    e.sinh     = y;
    e.residual = t;
    e.exp_pos  = {1'b0, x} + {1'b0, y};
    e.sat      = (y > x);
    e.exp_neg  = (y > x) ? '0 : (x - y);
    return e;
  endfunction

  // One clock of stimulus; inputs change on the falling edge and the handshakes
  // that will complete on the next rising edge are scored here.
  task automatic cycle(input logic iv, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] t, input logic ordy);
    exp_t e;
    exp_t got;
    @(negedge clk);
    in_valid  = iv;
    src_x     = x;
    src_y     = y;
    src_t     = t;
    out_ready = ordy;
    #1;
    if (reset && iv && in_ready) begin
      sb.push_back(model(x, y, t));
      accepts++;
    end
    if (out_valid && ordy) begin
      checks++;
      got = {out_cosh, out_sinh, out_exp_pos, out_exp_neg, out_residual, neg_sat};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got entry %h, expected no entry", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL pop_data: got %h expected %h", got, e);
        end
      end
      pops++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    src_x = '0; src_y = '0; src_t = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: out_valid=%b overflow=%b expected 0 0", out_valid, overflow);
    end
    checks++;
    if ({out_cosh, out_sinh, out_exp_pos, out_exp_neg, out_residual, neg_sat} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0",
               {out_cosh, out_sinh, out_exp_pos, out_exp_neg, out_residual, neg_sat});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_single();
    int lat = 0;
    cycle(1'b1, 16'h1000, 16'h0800, 16'h0003, 1'b1);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      cycle(1'b0, '0, '0, '0, 1'b1);
      if (out_valid) begin
        lat = k;
        checks++;
        if (out_exp_pos !== 17'h01800 || out_exp_neg !== 16'h0800 ||
            out_residual !== 16'h0003 || neg_sat !== 1'b0) begin
          errors++;
          $display("FAIL single_values: exp_pos=%h exp_neg=%h res=%h sat=%b expected 01800 0800 0003 0",
                   out_exp_pos, out_exp_neg, out_residual, neg_sat);
        end
      end
    end
    checks++;
    if (lat != 13) begin
      errors++;
      $display("FAIL single_latency: got %0d edges expected 13 (0 = timeout)", lat);
    end
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    for (int c = 0; c < 5; c++)
      cycle(c < 3, W'($urandom), W'($urandom), W'($urandom), 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flags: out_valid=%b overflow=%b expected 0 0", out_valid, overflow);
    end
    reset = 1'b1;
    sb.delete();
    cycle(1'b0, '0, '0, '0, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_in_ready: got %b expected 1", in_ready);
    end
    for (int c = 0; c < 30; c++) begin
      cycle(1'b0, '0, '0, '0, 1'b1);
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL midreset_stale: stale=%0d overflow=%b expected 0 0", stale, overflow);
    end
  endtask

  task automatic test_backpressure();
    int a0 = accepts;
    int p0 = pops;
    repeat (20) cycle(1'b1, W'($urandom), W'($urandom), W'($urandom), 1'b0);
    checks++;
    if (accepts - a0 != 4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accepts: accepts=%0d in_ready=%b expected 4 0", accepts - a0, in_ready);
    end
    checks++;
    if (out_valid !== 1'b1 || dut.occupancy !== 3'd4) begin
      errors++;
      $display("FAIL bp_full: out_valid=%b occupancy=%0d expected 1 4", out_valid, dut.occupancy);
    end
    repeat (8) cycle(1'b0, '0, '0, '0, 1'b1);
    checks++;
    if (pops - p0 != 4 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: pops=%0d left=%0d expected 4 0", pops - p0, sb.size());
    end
    checks++;
    if (in_ready !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL bp_recover: in_ready=%b overflow=%b expected 1 0", in_ready, overflow);
    end
  endtask

  task automatic test_saturation();
    int seen = 0;
    cycle(1'b1, 16'h0100, 16'h0200, 16'h0005, 1'b1);
    cycle(1'b1, 16'hFFFF, 16'hFFFF, 16'h0007, 1'b1);
    for (int k = 0; k < 40 && seen < 2; k++) begin
      cycle(1'b0, '0, '0, '0, 1'b1);
      if (out_valid) begin
        seen++;
        checks++;
        if (seen == 1 && (out_exp_neg !== 16'h0000 || neg_sat !== 1'b1)) begin
          errors++;
          $display("FAIL sat_neg: exp_neg=%h neg_sat=%b expected 0000 1", out_exp_neg, neg_sat);
        end else if (seen == 2 && out_exp_pos !== 17'h1FFFE) begin
          errors++;
          $display("FAIL sat_pos_width: exp_pos=%h expected 1fffe", out_exp_pos);
        end
      end
    end
    checks++;
    if (seen != 2) begin
      errors++;
      $display("FAIL sat_count: got %0d results expected 2", seen);
    end
  endtask

  task automatic test_stream();
    int a0 = accepts;
    int p0 = pops;
    for (int c = 0; c < 20000 && (accepts - a0 < 1000 || sb.size() != 0); c++)
      cycle((accepts - a0) < 1000, W'($urandom), W'($urandom), W'($urandom),
            1'($urandom_range(0, 1)));
    checks++;
    if (accepts - a0 != 1000 || pops - p0 != 1000 || sb.size() != 0) begin
      errors++;
      $display("FAIL stream_count: accepts=%0d pops=%0d left=%0d expected 1000 1000 0",
               accepts - a0, pops - p0, sb.size());
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL stream_overflow: got %b expected 0", overflow);
    end
  endtask

  task automatic test_overflow();
    int p0;
    repeat (4) cycle(1'b1, W'($urandom), W'($urandom), W'($urandom), 1'b0);
    repeat (16) cycle(1'b0, '0, '0, '0, 1'b0);
    checks++;
    if (dut.occupancy !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_prefill: occupancy=%0d overflow=%b expected 4 0", dut.occupancy, overflow);
    end
    @(negedge clk);
    force dut.vld = 12'h800;
    @(negedge clk);
    release dut.vld;
    repeat (3) cycle(1'b0, '0, '0, '0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || dut.occupancy !== 3'd4) begin
      errors++;
      $display("FAIL ovf_set: overflow=%b occupancy=%0d expected 1 4", overflow, dut.occupancy);
    end
    p0 = pops;
    repeat (8) cycle(1'b0, '0, '0, '0, 1'b1);
    checks++;
    if (pops - p0 != 4 || sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_contents: pops=%0d left=%0d out_valid=%b expected 4 0 0",
               pops - p0, sb.size(), out_valid);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b expected 1", overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_midstream();
    test_backpressure();
    test_saturation();
    test_stream();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
